req_grant_arbiter: RTL and testbench
====================================

Name: req_grant_arbiter

Overview:
- Round-robin arbiter that produces the grant half of the req/grant handshake checked by the team's protocol assertions.
- Takes N level requests and issues a one-hot registered grant after a fixed, parameterised delay.
- Holds the grant while the owner's request stays high and revokes it on release or on hold timeout.
- Sits directly downstream of the requesters and upstream of the shared resource.

Parameters:
- N, 4, number of requesters (2..8).
- GRANT_DLY, 2, edges from arbitration to grant assertion (legal 1..4).
- MAX_HOLD, 16, maximum grant length in cycles; 0 disables the timeout.

Ports:
- clk  input  1  single clock, all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- req  input  N  level request per requester.
- gnt  output  N  one-hot grant, registered.
- gnt_id  output  $clog2(N)  index of current owner; valid while busy=1.
- busy  output  1  high from arbitration edge until return to IDLE.
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- Reset (rst=1 sampled at posedge):
  - Next edge: gnt=0, gnt_id=0, busy=0, timeout=0, state=IDLE, last=N-1, mask=0.
  - Applies from any state, mid-grant included; a grant drops on that edge.
- FSM states: IDLE, WAIT, GRANT.
- IDLE:
  - At edge k, eligible = req & ~mask. If nonzero, pick the first set bit searching from last+1 upward with wrap-around.
  - Register gnt_id=winner, busy=1, dly_cnt=GRANT_DLY-1, go to WAIT.
  - The winner is fixed at edge k; later request changes do not re-arbitrate.
- WAIT:
  - If req[gnt_id]=0 is sampled: abort. Go to IDLE with busy=0, no grant issued, last unchanged.
  - Else if dly_cnt=0: gnt[gnt_id]=1, last=gnt_id, hold_cnt=1, go to GRANT.
  - Else decrement dly_cnt.
- Resulting latency: gnt is driven high at edge k+GRANT_DLY and is first sampled high at edge k+GRANT_DLY+1. For GRANT_DLY 1..4 this lands 2..5 edges after the request is first sampled high.
- GRANT:
  - If req[gnt_id]=0 is sampled at edge m: gnt=0, busy=0, go to IDLE. New arbitration can occur at edge m+1 at the earliest.
  - Else if MAX_HOLD≠0 and hold_cnt=MAX_HOLD: gnt=0, busy=0, timeout=1 for one cycle, set mask[gnt_id]=1, go to IDLE.
  - Else hold_cnt++. hold_cnt is wide enough for MAX_HOLD; it never wraps.
- Mask: mask[i] clears on any edge where req[i]=0 is sampled. A timed-out requester must drop and re-raise req before it is eligible again.
- Invariants: gnt is one-hot or zero; gnt≠0 implies busy=1 and state=GRANT.
- Simultaneous requests are resolved purely by round-robin order; no requester is granted twice while another eligible requester is waiting.
- Illegal GRANT_DLY (0 or >4) is a configuration error; the implementation carries an elaboration-time check.

Test Plan:
- Reset, then req=4'b0001 held (first sampled high at edge 3), GRANT_DLY=2 -> gnt=4'b0001 driven at edge 5, gnt_id=0, busy=1 from edge 3. Drop req at edge 10 -> gnt=0, busy=0 at edge 10.
- req=4'b1111 held continuously, MAX_HOLD=0; each owner drops req after 3 grant cycles, then re-raises -> grant order 0,1,2,3,0, with gnt never two-hot.
- req=4'b0010 raised, then dropped after 1 cycle, during WAIT with GRANT_DLY=4 -> no gnt pulse, busy falls, last stays 3, and a later req[0] wins before req[1].
- MAX_HOLD=4, req[2] held forever -> gnt[2] high for exactly 4 cycles, timeout pulses once, and req[2] is not re-granted until it is lowered for at least 1 cycle and raised again.
- Sweep GRANT_DLY=1..4 with a single rising request -> gnt first sampled high 2,3,4,5 edges after req is first sampled high; the bench assertion "rise of req implies grant within 1..4 cycles after next edge" passes for all four values.
- rst=1 asserted while in GRANT with gnt=4'b0100 -> on that edge gnt=0, busy=0, timeout=0. After rst=0, a pending req[0] wins first (last=N-1).

Source files
------------

// File: rtl/req_grant_arbiter.sv
// rtl/req_grant_arbiter.sv - round-robin req/grant arbiter with delayed grant and hold timeout
module req_grant_arbiter #(
    parameter int N         = 4,
    parameter int GRANT_DLY = 2,
    parameter int MAX_HOLD  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 busy,
    output logic                 timeout
);

    localparam int IDW = $clog2(N);
    localparam int HW  = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

    generate
        if (GRANT_DLY < 1 || GRANT_DLY > 4) begin : g_bad_dly
            $error("req_grant_arbiter: GRANT_DLY must be 1..4");
        end
        if (N < 2 || N > 8) begin : g_bad_n
            $error("req_grant_arbiter: N must be 2..8");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, WAIT, GRANT} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic [IDW-1:0] last_q, last_d;
    logic [N-1:0]   mask_q, mask_d;
    logic [1:0]     dly_cnt_q, dly_cnt_d;
    logic [HW-1:0]  hold_cnt_q, hold_cnt_d;
    logic           busy_q, busy_d;
    logic           timeout_q, timeout_d;

    logic [N-1:0]   eligible;
    logic           win_found;
    logic [IDW-1:0] win_id;
    logic           owner_req;
    logic           hold_expire;

    // Round-robin search starts just past the last requester that was actually granted.
    always_comb begin
        eligible  = req & ~mask_q;
        win_found = 1'b0;
        win_id    = '0;
        for (int i = 1; i <= N; i++) begin
            if (!win_found && eligible[IDW'((int'(last_q) + i) % N)]) begin
                win_found = 1'b1;
                win_id    = IDW'((int'(last_q) + i) % N);
            end
        end
    end

    assign owner_req   = req[gnt_id_q];
    assign hold_expire = (MAX_HOLD != 0) && (hold_cnt_q == HW'(MAX_HOLD));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_found) state_d = WAIT;
            WAIT:    if (!owner_req) state_d = IDLE;
                     else if (dly_cnt_q == 2'd0) state_d = GRANT;
            GRANT:   if (!owner_req || hold_expire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        last_d     = last_q;
        dly_cnt_d  = dly_cnt_q;
        hold_cnt_d = hold_cnt_q;
        busy_d     = busy_q;
        timeout_d  = 1'b0;
        // A dropped request always clears its timeout lockout.
        mask_d     = mask_q & req;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    gnt_id_d  = win_id;
                    busy_d    = 1'b1;
                    dly_cnt_d = 2'(GRANT_DLY - 1);
                end
            end
            WAIT: begin
                if (!owner_req) begin
                    busy_d = 1'b0;
                end else if (dly_cnt_q == 2'd0) begin
                    gnt_d      = N'(1) << gnt_id_q;
                    last_d     = gnt_id_q;
                    hold_cnt_d = HW'(1);
                end else begin
                    dly_cnt_d = dly_cnt_q - 2'd1;
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    gnt_d  = '0;
                    busy_d = 1'b0;
                end else if (hold_expire) begin
                    gnt_d            = '0;
                    busy_d           = 1'b0;
                    timeout_d        = 1'b1;
                    mask_d[gnt_id_q] = 1'b1;
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            default: begin
                gnt_d  = '0;
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            last_q     <= IDW'(N - 1);
            mask_q     <= '0;
            dly_cnt_q  <= '0;
            hold_cnt_q <= '0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            last_q     <= last_d;
            mask_q     <= mask_d;
            dly_cnt_q  <= dly_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_req_grant_arbiter.sv
// tb/tb_req_grant_arbiter.sv - scoreboard bench over four arbiter configurations
module tb_req_grant_arbiter;

    localparam int NI = 4;

    function automatic int mh_of(input int k);
        case (k)
            0:       return 0;
            1:       return 4;
            2:       return 16;
            default: return 3;
        endcase
    endfunction

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] id;
        logic       busy;
        logic       timeout;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;

    logic [3:0] gnt_w  [NI];
    logic [1:0] id_w   [NI];
    logic       busy_w [NI];
    logic       to_w   [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        req_grant_arbiter #(
            .N(4), .GRANT_DLY(g + 1), .MAX_HOLD(mh_of(g))
        ) dut (
            .clk(clk), .rst(rst), .req(req),
            .gnt(gnt_w[g]), .gnt_id(id_w[g]), .busy(busy_w[g]), .timeout(to_w[g])
        );
    end

    // Transaction-level model: an owner, the edge it was chosen, and the edge its grant began.
    int       m_owner [NI];
    int       m_arb   [NI];
    int       m_gedge [NI];
    int       m_last  [NI];
    int       m_id    [NI];
    bit       m_grant [NI];
    bit [3:0] m_mask  [NI];
    exp_t     exp_q   [NI][$];
    int       edge_n  = 0;
    bit       started = 1'b0;
    int       tests   = 0;
    int       fails   = 0;

    task automatic model_reset(input int k);
        m_owner[k] = -1;
        m_grant[k] = 1'b0;
        m_last[k]  = 3;
        m_id[k]    = 0;
        m_mask[k]  = 4'b0000;
    endtask

    task automatic model_step(input int k, input logic [3:0] r, input int e);
        exp_t x;
        x.timeout = 1'b0;
        if (m_owner[k] < 0) begin
            for (int i = 1; i <= 4; i++) begin
                int c;
                c = (m_last[k] + i) % 4;
                if (m_owner[k] < 0 && r[c] && !m_mask[k][c]) begin
                    m_owner[k] = c;
                    m_arb[k]   = e;
                    m_id[k]    = c;
                end
            end
        end else if (!m_grant[k]) begin
            if (!r[m_owner[k]]) begin
                m_owner[k] = -1;
            end else if (e - m_arb[k] == k + 1) begin
                m_grant[k] = 1'b1;
                m_gedge[k] = e;
                m_last[k]  = m_owner[k];
            end
        end else begin
            if (!r[m_owner[k]]) begin
                m_owner[k] = -1;
                m_grant[k] = 1'b0;
            end else if (mh_of(k) != 0 && e - m_gedge[k] == mh_of(k)) begin
                x.timeout = 1'b1;
                m_mask[k][m_owner[k]] = 1'b1;
                m_owner[k] = -1;
                m_grant[k] = 1'b0;
            end
        end
        m_mask[k] = m_mask[k] & r;
        x.gnt  = m_grant[k] ? (4'b0001 << m_owner[k]) : 4'b0000;
        x.busy = (m_owner[k] >= 0);
        x.id   = 2'(m_id[k]);
        exp_q[k].push_back(x);
    endtask

    always @(posedge clk) begin
        edge_n++;
        for (int k = 0; k < NI; k++) begin
            if (rst) begin
                model_reset(k);
                exp_q[k].push_back(exp_t'(0));
            end else if (started) begin
                model_step(k, req, edge_n);
            end
        end
        if (rst) started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < NI; k++) begin
                exp_t x;
                tests++;
                if (exp_q[k].size() == 0) begin
                    fails++;
                    $display("FAIL cfg%0d no_expected t=%0t", k, $time);
                end else begin
                    x = exp_q[k].pop_front();
                    if (gnt_w[k] !== x.gnt || busy_w[k] !== x.busy || to_w[k] !== x.timeout ||
                        (x.busy && id_w[k] !== x.id)) begin
                        fails++;
                        $display("FAIL cfg%0d outputs t=%0t got gnt=%b id=%0d busy=%b to=%b want gnt=%b id=%0d busy=%b to=%b",
                                 k, $time, gnt_w[k], id_w[k], busy_w[k], to_w[k],
                                 x.gnt, x.id, x.busy, x.timeout);
                    end
                end
            end
        end
    end

    task automatic drive(input logic [3:0] r, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            req = r;
        end
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drive(4'b0001, 12);
        drive(4'b0000, 3);
        drive(4'b1111, 40);
        drive(4'b0000, 2);
        drive(4'b0010, 1);
        drive(4'b0000, 1);
        drive(4'b0011, 20);
        drive(4'b0100, 30);
        drive(4'b0000, 1);
        drive(4'b0100, 10);
        @(negedge clk);
        rst = 1'b1;
        req = 4'b0101;
        @(negedge clk);
        rst = 1'b0;
        drive(4'b0101, 12);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
            end
            rst = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(4'b0000, 6);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
